// File: rtl/nios_multi_interval_timer.sv
// Multi-channel Avalon-MM interval timer: NUM_CHANNELS prescaled down-counters with
// period reload, one-shot/continuous mode, snapshot capture and per-channel timeout irq.
module nios_multi_interval_timer #(
  parameter int          NUM_CHANNELS   = 4,
  parameter int          COUNTER_WIDTH  = 32,
  parameter int unsigned DEFAULT_PERIOD = 49999,
  parameter int          PRESCALE_WIDTH = 16,
  localparam int         CH_BITS        = $clog2(NUM_CHANNELS),
  localparam int         AW             = 3 + CH_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AW-1:0]           address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [15:0]             writedata,
  output logic [15:0]             readdata,
  output logic [NUM_CHANNELS-1:0] irq_vec,
  output logic                    irq
);

  localparam logic [COUNTER_WIDTH-1:0] RST_CNT = COUNTER_WIDTH'(DEFAULT_PERIOD);

  logic [COUNTER_WIDTH-1:0]  counter   [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0]  period    [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0]  snap      [NUM_CHANNELS];
  logic [31:0]               period_ext[NUM_CHANNELS];
  logic [31:0]               snap_ext  [NUM_CHANNELS];
  logic [3:0]                control   [NUM_CHANNELS];
  logic [PRESCALE_WIDTH-1:0] prescale  [NUM_CHANNELS];
  logic [PRESCALE_WIDTH-1:0] pre_cnt   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   run;
  logic [NUM_CHANNELS-1:0]   to;
  logic [NUM_CHANNELS-1:0]   force_reload;
  logic [NUM_CHANNELS-1:0]   sel;
  logic [NUM_CHANNELS-1:0]   tick;
  logic [AW-1:0]             addr_ch;
  logic [2:0]                offset;
  logic                      wr_en;
  logic [15:0]               rd_mux;

  assign addr_ch = address >> 3;
  assign offset  = address[2:0];
  assign wr_en   = chipselect & ~write_n;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      sel[c]        = wr_en && (addr_ch == AW'(c));
      tick[c]       = run[c] && (pre_cnt[c] == '0);
      period_ext[c] = 32'(period[c]);
      snap_ext[c]   = 32'(snap[c]);
      irq_vec[c]    = to[c] & control[c][0];
    end
  end

  assign irq = |irq_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        counter[c]      <= RST_CNT;
        period[c]       <= RST_CNT;
        snap[c]         <= '0;
        control[c]      <= '0;
        prescale[c]     <= '0;
        pre_cnt[c]      <= '0;
        run[c]          <= 1'b0;
        to[c]           <= 1'b0;
        force_reload[c] <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        // Prescaler holds at its reload value while stopped so the first tick is a full interval away.
        if (!run[c] || tick[c])
          pre_cnt[c] <= prescale[c];
        else
          pre_cnt[c] <= pre_cnt[c] - 1'b1;

        force_reload[c] <= sel[c] && (offset == 3'd2 || offset == 3'd3);

        if (force_reload[c]) begin
          counter[c] <= period[c];
          run[c]     <= 1'b0;
        end else if (tick[c]) begin
          if (counter[c] != '0) begin
            counter[c] <= counter[c] - 1'b1;
          end else begin
            counter[c] <= period[c];
            if (!control[c][1])
              run[c] <= 1'b0;
          end
        end

        if (sel[c] && offset == 3'd0)
          to[c] <= 1'b0;
        // Placed after the clear so a timeout in the same cycle as a STATUS write is not lost.
        if (!force_reload[c] && tick[c] && counter[c] == '0)
          to[c] <= 1'b1;

        if (sel[c]) begin
          case (offset)
            3'd1: begin
              control[c] <= writedata[3:0];
              if (writedata[2])
                run[c] <= 1'b1;
              else if (writedata[3])
                run[c] <= 1'b0;
            end
            3'd2: period[c][15:0] <= writedata;
            3'd3: period[c][COUNTER_WIDTH-1:16] <= writedata[COUNTER_WIDTH-17:0];
            3'd4, 3'd5: snap[c] <= counter[c];
            3'd6: prescale[c] <= writedata[PRESCALE_WIDTH-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (addr_ch == AW'(c)) begin
        case (offset)
          3'd0:    rd_mux = {14'b0, run[c], to[c]};
          3'd1:    rd_mux = {12'b0, control[c]};
          3'd2:    rd_mux = period_ext[c][15:0];
          3'd3:    rd_mux = period_ext[c][31:16];
          3'd4:    rd_mux = snap_ext[c][15:0];
          3'd5:    rd_mux = snap_ext[c][31:16];
          3'd6:    rd_mux = 16'(prescale[c]);
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      readdata <= '0;
    else
      readdata <= rd_mux;
  end

endmodule
